// File: rtl/serial_negate_pkg.sv
// Shared types and constants for the serial two's-complement negator.
// Holds the controller state encoding and the most-negative-value helper.
package serial_negate_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // 1 followed by w-1 zeros, right-aligned in a 32-bit word
    function automatic logic [31:0] most_neg(input int w);
        logic [31:0] v;
        v = 32'd1 << (w - 1);
        return v;
    endfunction

endpackage

// File: rtl/serial_twos_comp.sv
// Bit-serial two's-complement cell: invert every bit after the first one.
// z is combinational from x so it is valid in the cycle x is presented.
module serial_twos_comp
    import serial_negate_pkg::*;
(
    input  logic clk,
    input  logic areset,
    input  logic clr,
    input  logic en,
    input  logic x,
    output logic z
);

    logic seen_one;

    // Remember whether a 1 has already passed through this operand
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            seen_one <= 1'b0;
        end else if (clr) begin
            seen_one <= 1'b0;
        end else if (en && x) begin
            seen_one <= 1'b1;
        end
    end

    assign z = x ^ seen_one;

endmodule

// File: rtl/serial_negate_ctrl.sv
// Handshaked controller that negates one operand LSB-first over WIDTH cycles.
// Holds the result in DONE until the consumer takes it.
module serial_negate_ctrl
    import serial_negate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(most_neg(WIDTH));
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] res;
    logic             ovf_r;
    logic             accept;
    logic             last;
    logic             z;

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state == ST_SHIFT);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (cnt == LAST_CNT);
    assign out_data  = out_valid ? res : '0;
    assign out_ovf   = out_valid && ovf_r;

    serial_twos_comp u_dp (
        .clk    (clk),
        .areset (areset),
        .clr    (accept),
        .en     (busy),
        .x      (opnd[0]),
        .z      (z)
    );

    // Next-state selection for the IDLE -> SHIFT -> DONE loop
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (accept)    state_nx = ST_SHIFT;
            ST_SHIFT: if (last)      state_nx = ST_DONE;
            ST_DONE:  if (out_ready) state_nx = ST_IDLE;
            default:                 state_nx = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Operand capture, bit counter and serial result assembly
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            cnt   <= '0;
            opnd  <= '0;
            res   <= '0;
            ovf_r <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            opnd  <= in_data;
            res   <= '0;
            ovf_r <= (in_data == MOST_NEG);
        end else if (busy) begin
            cnt  <= cnt + 1'b1;
            opnd <= opnd >> 1;
            res  <= {z, res[WIDTH-1:1]};
        end
    end

endmodule

// File: tb/tb_serial_negate_ctrl.sv
// Directed and randomized checks of serial_negate_ctrl at WIDTH=8.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_serial_negate_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         areset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_ovf;
    logic         busy;

    int n_checks;
    int n_fail;

    serial_negate_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .areset    (areset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offer op, wait for accept, then count cycles until out_valid.
    // lat is cycles after the accept cycle; -1 on timeout.
    task automatic send_and_wait(input logic [W-1:0] op,
                                 output logic [W-1:0] data,
                                 output logic ovf,
                                 output int lat);
        int k;
        data = '0;
        ovf  = 1'b0;
        lat  = -1;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = op;
        k = 0;
        while (!in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'hA5;
        for (int c = 1; c < 40; c++) begin
            if (out_valid) begin
                lat  = c;
                data = out_data;
                ovf  = out_ovf;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        areset    = 1'b1;
        #2;
        n_checks++;
        if ({in_ready, out_valid, busy, out_ovf, out_data} !== {4'b1000, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b ov=%b busy=%b ovf=%b d=%h want 1 0 0 0 00",
                     in_ready, out_valid, busy, out_ovf, out_data);
        end
        repeat (2) @(negedge clk);
        areset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got rdy=%b busy=%b want 1 0", in_ready, busy);
        end
    endtask

    task automatic test_latency();
        int bad_busy;
        int k;
        int lat;
        bad_busy  = 0;
        lat       = -1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h01;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL lat_ready: got in_ready=%b want 1", in_ready);
        end
        for (k = 1; k <= 12; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (k <= 8 && (busy !== 1'b1 || out_valid !== 1'b0)) bad_busy++;
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        n_checks++;
        if (bad_busy != 0) begin
            n_fail++;
            $display("FAIL lat_busy: %0d cycles with wrong busy/out_valid want 0", bad_busy);
        end
        n_checks++;
        if (lat != 9) begin
            n_fail++;
            $display("FAIL lat_cycles: got %0d want 9", lat);
        end
        n_checks++;
        if (out_data !== 8'hFF || out_ovf !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_result: got d=%h ovf=%b busy=%b want ff 0 0",
                     out_data, out_ovf, busy);
        end
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL lat_idle: got rdy=%b ov=%b d=%h want 1 0 00",
                     in_ready, out_valid, out_data);
        end
    endtask

    task automatic test_zero_ovf();
        logic [W-1:0] d;
        logic         o;
        int           lat;
        out_ready = 1'b1;
        send_and_wait(8'h00, d, o, lat);
        n_checks++;
        if (d !== 8'h00 || o !== 1'b0 || lat != 9) begin
            n_fail++;
            $display("FAIL zero: got d=%h ovf=%b lat=%0d want 00 0 9", d, o, lat);
        end
        send_and_wait(8'h80, d, o, lat);
        n_checks++;
        if (d !== 8'h80 || o !== 1'b1 || lat != 9) begin
            n_fail++;
            $display("FAIL most_neg: got d=%h ovf=%b lat=%0d want 80 1 9", d, o, lat);
        end
        send_and_wait(8'h81, d, o, lat);
        n_checks++;
        if (d !== 8'h7F || o !== 1'b0) begin
            n_fail++;
            $display("FAIL near_neg: got d=%h ovf=%b want 7f 0", d, o);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int           n_acc;
        int           n_res;
        int           acc_cyc[2];
        logic [W-1:0] got[2];
        n_acc     = 0;
        n_res     = 0;
        acc_cyc   = '{-1, -1};
        got       = '{8'h00, 8'h00};
        out_ready = 1'b1;
        for (int i = 0; i < 60 && n_res < 2; i++) begin
            @(negedge clk);
            in_data  = (n_acc == 0) ? 8'h05 : 8'h7F;
            in_valid = (n_acc < 2);
            if (out_valid === 1'b1) begin
                got[n_res] = out_data;
                n_res++;
            end
            if (in_valid && in_ready === 1'b1 && n_acc < 2) begin
                acc_cyc[n_acc] = i;
                n_acc++;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (n_res != 2 || got[0] !== 8'hFB || got[1] !== 8'h81) begin
            n_fail++;
            $display("FAIL b2b_data: got n=%0d %h %h want 2 fb 81", n_res, got[0], got[1]);
        end
        n_checks++;
        if (acc_cyc[1] - acc_cyc[0] != 10) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d want 10", acc_cyc[1] - acc_cyc[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        logic [W-1:0] d;
        logic         o;
        int           lat;
        int           bad;
        bad       = 0;
        out_ready = 1'b0;
        send_and_wait(8'h01, d, o, lat);
        n_checks++;
        if (d !== 8'hFF || lat != 9) begin
            n_fail++;
            $display("FAIL stall_first: got d=%h lat=%0d want ff 9", d, lat);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'h33;
            if (out_valid !== 1'b1 || out_data !== 8'hFF || out_ovf !== 1'b0 ||
                in_ready !== 1'b0 || busy !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stall_hold: %0d unstable cycles want 0", bad);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL stall_release: got rdy=%b ov=%b d=%h want 1 0 00",
                     in_ready, out_valid, out_data);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] d;
        logic         o;
        int           lat;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h3C;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_busy: got busy=%b want 1", busy);
        end
        areset = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, out_valid, busy, out_ovf, out_data} !== {4'b1000, 8'h00}) begin
            n_fail++;
            $display("FAIL rmid_reset: got rdy=%b ov=%b busy=%b ovf=%b d=%h want 1 0 0 0 00",
                     in_ready, out_valid, busy, out_ovf, out_data);
        end
        @(negedge clk);
        areset = 1'b0;
        send_and_wait(8'h3C, d, o, lat);
        n_checks++;
        if (d !== 8'hC4 || o !== 1'b0 || lat != 9) begin
            n_fail++;
            $display("FAIL rmid_after: got d=%h ovf=%b lat=%0d want c4 0 9", d, o, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int           n_ops;
        int           n_done;
        int           cyc;
        int           acc_cyc;
        logic         pend;
        logic         seen;
        logic [W-1:0] op;
        logic [W-1:0] exp_d;
        logic         exp_o;
        n_ops  = 0;
        n_done = 0;
        cyc    = 0;
        acc_cyc = 0;
        pend   = 1'b0;
        seen   = 1'b0;
        op     = '0;
        while (n_ops < 400 && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            exp_d = W'(~op + 1'b1);
            exp_o = (op == 8'h80);
            if (out_valid === 1'b1) begin
                n_checks++;
                if (!pend || out_data !== exp_d || out_ovf !== exp_o) begin
                    n_fail++;
                    $display("FAIL rand_result: op=%h got d=%h ovf=%b want %h %b pend=%b",
                             op, out_data, out_ovf, exp_d, exp_o, pend);
                end
                if (!seen) begin
                    seen = 1'b1;
                    n_checks++;
                    if (cyc - acc_cyc != 9) begin
                        n_fail++;
                        $display("FAIL rand_latency: op=%h got %0d want 9", op, cyc - acc_cyc);
                    end
                end
            end else if (out_data !== 8'h00 || out_ovf !== 1'b0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rand_idle_out: got d=%h ovf=%b want 00 0", out_data, out_ovf);
            end
            areset    = ($urandom_range(31) == 0);
            in_valid  = ($urandom_range(3) != 0);
            in_data   = W'($urandom);
            out_ready = ($urandom_range(2) != 0);
            #1;
            if (areset) begin
                pend = 1'b0;
            end else begin
                if (pend && out_valid && out_ready) begin
                    pend = 1'b0;
                    n_done++;
                end
                if (in_valid && in_ready === 1'b1) begin
                    pend    = 1'b1;
                    seen    = 1'b0;
                    op      = in_data;
                    acc_cyc = cyc;
                    n_ops++;
                end
            end
        end
        @(negedge clk);
        areset   = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (n_ops < 400 || n_done < 100) begin
            n_fail++;
            $display("FAIL rand_progress: got ops=%0d done=%0d want 400 and >=100",
                     n_ops, n_done);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_latency();
        test_zero_ovf();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
